// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the sequencer's decoder/flag inputs and its control strobes so the
// sequencer and the datapath it steers can share one connection.
//   master : the sequencer (consumes INTR/BR_OP/Z/C, drives the strobes)
//   slave  : the datapath side (drives INTR/BR_OP/Z/C, consumes the strobes)
// Signals:
//   INTR, BR_OP[3:0], Z, C                     decoder / flag / interrupt inputs
//   RST_OUT, IR_LD, PC_INC, PC_LD, PC_MUX_SEL  fetch and PC control
//   SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL     stack control
//   FLG_SHAD_SAVE, FLG_SHAD_RESTORE            flag shadow control
//   INT_ACK, IE, STATE[1:0]                    interrupt status and FSM state
interface pc_sequencer_if;
    logic       INTR;
    logic [3:0] BR_OP;
    logic       Z;
    logic       C;
    logic       RST_OUT;
    logic       IR_LD;
    logic       PC_INC;
    logic       PC_LD;
    logic [1:0] PC_MUX_SEL;
    logic       SP_INCR;
    logic       SP_DECR;
    logic       SCR_WE;
    logic       SCR_ADDR_SEL;
    logic       FLG_SHAD_SAVE;
    logic       FLG_SHAD_RESTORE;
    logic       INT_ACK;
    logic       IE;
    logic [1:0] STATE;

    modport master (
        input  INTR, BR_OP, Z, C,
        output RST_OUT, IR_LD, PC_INC, PC_LD, PC_MUX_SEL,
               SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL,
               FLG_SHAD_SAVE, FLG_SHAD_RESTORE, INT_ACK, IE, STATE
    );

    modport slave (
        output INTR, BR_OP, Z, C,
        input  RST_OUT, IR_LD, PC_INC, PC_LD, PC_MUX_SEL,
               SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL,
               FLG_SHAD_SAVE, FLG_SHAD_RESTORE, INT_ACK, IE, STATE
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Control FSM for the RAT CPU: sequences fetch/execute, PC loads, stack
// push/pop, flag shadowing and interrupt entry. Only the state and the
// interrupt-enable flag are registered; every strobe is decoded
// combinationally from the state (and BR_OP/Z/C while executing).
// Ports:
//   CLK  system clock
//   RST  synchronous active-high reset (forces INIT and clears IE)
//   bus  pc_sequencer_if.master, see the interface for the signal list
// Parameter:
//   INT_VEC  interrupt vector; the PC mux itself applies it on PC_MUX_SEL=2
module pc_sequencer #(
    parameter logic [9:0] INT_VEC = 10'h3FF
) (
    input  logic            CLK,
    input  logic            RST,
    pc_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [3:0] OP_BRN   = 4'd1;
    localparam logic [3:0] OP_BREQ  = 4'd2;
    localparam logic [3:0] OP_BRNE  = 4'd3;
    localparam logic [3:0] OP_BRCS  = 4'd4;
    localparam logic [3:0] OP_BRCC  = 4'd5;
    localparam logic [3:0] OP_CALL  = 4'd6;
    localparam logic [3:0] OP_RET   = 4'd7;
    localparam logic [3:0] OP_RETID = 4'd8;
    localparam logic [3:0] OP_RETIE = 4'd9;
    localparam logic [3:0] OP_SEI   = 4'd10;
    localparam logic [3:0] OP_CLI   = 4'd11;

    localparam logic [1:0] MUX_IMM  = 2'd0;
    localparam logic [1:0] MUX_RET  = 2'd1;
    localparam logic [1:0] MUX_VEC  = 2'd2;

    state_t state_q, state_d;
    logic   ie_q, ie_d;

    logic       rst_out;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_mux_sel;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic       scr_addr_sel;
    logic       flg_shad_save;
    logic       flg_shad_restore;
    logic       int_ack;
    logic       br_taken;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ie_d             = ie_q;
        rst_out          = 1'b0;
        ir_ld            = 1'b0;
        pc_inc           = 1'b0;
        pc_ld            = 1'b0;
        pc_mux_sel       = MUX_IMM;
        sp_incr          = 1'b0;
        sp_decr          = 1'b0;
        scr_we           = 1'b0;
        scr_addr_sel     = 1'b0;
        flg_shad_save    = 1'b0;
        flg_shad_restore = 1'b0;
        int_ack          = 1'b0;
        br_taken         = 1'b0;

        case (state_q)
            ST_INIT: begin
                rst_out = 1'b1;
                ie_d    = 1'b0;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                case (bus.BR_OP)
                    OP_BRN:   br_taken = 1'b1;
                    OP_BREQ:  br_taken = bus.Z;
                    OP_BRNE:  br_taken = ~bus.Z;
                    OP_BRCS:  br_taken = bus.C;
                    OP_BRCC:  br_taken = ~bus.C;
                    OP_CALL: begin
                        // Push the incremented PC at SP-1 while jumping.
                        pc_ld        = 1'b1;
                        pc_mux_sel   = MUX_IMM;
                        scr_we       = 1'b1;
                        scr_addr_sel = 1'b1;
                        sp_decr      = 1'b1;
                    end
                    OP_RET, OP_RETID, OP_RETIE: begin
                        // Pop: the scratch read at SP is asynchronous, so the
                        // return address is on the PC mux this same cycle.
                        pc_ld            = 1'b1;
                        pc_mux_sel       = MUX_RET;
                        scr_addr_sel     = 1'b0;
                        sp_incr          = 1'b1;
                        flg_shad_restore = (bus.BR_OP != OP_RET);
                        if (bus.BR_OP == OP_RETID) ie_d = 1'b0;
                        if (bus.BR_OP == OP_RETIE) ie_d = 1'b1;
                    end
                    OP_SEI:   ie_d = 1'b1;
                    OP_CLI:   ie_d = 1'b0;
                    default:  ;
                endcase

                if (br_taken) begin
                    pc_ld      = 1'b1;
                    pc_mux_sel = MUX_IMM;
                end

                // Use the post-update enable so SEI/RETIE take effect at once
                // and CLI/RETID mask a request already pending.
                state_d = (bus.INTR && ie_d) ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                // Push the current PC (already the next instruction or the
                // branch target) and vector; interrupts stay off in the ISR.
                pc_ld         = 1'b1;
                pc_mux_sel    = MUX_VEC;
                scr_we        = 1'b1;
                scr_addr_sel  = 1'b1;
                sp_decr       = 1'b1;
                flg_shad_save = 1'b1;
                int_ack       = 1'b1;
                ie_d          = 1'b0;
                state_d       = ST_FETCH;
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign bus.RST_OUT          = rst_out;
    assign bus.IR_LD            = ir_ld;
    assign bus.PC_INC           = pc_inc;
    assign bus.PC_LD            = pc_ld;
    assign bus.PC_MUX_SEL       = pc_mux_sel;
    assign bus.SP_INCR          = sp_incr;
    assign bus.SP_DECR          = sp_decr;
    assign bus.SCR_WE           = scr_we;
    assign bus.SCR_ADDR_SEL     = scr_addr_sel;
    assign bus.FLG_SHAD_SAVE    = flg_shad_save;
    assign bus.FLG_SHAD_RESTORE = flg_shad_restore;
    assign bus.INT_ACK          = int_ack;
    assign bus.IE               = ie_q;
    assign bus.STATE            = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control FSM that sequences the program counter, the stack pointer and interrupt entry/exit for the RAT CPU. It drives PC load/increment and source select, stack push/pop strobes, flag shadow save/restore and the interrupt-enable flag. Instruction flow class and flags come from the instruction decoder and ALU flag registers.

## Interface
Parameters:
- INT_VEC, 10'h3FF, interrupt vector. Informational only; the PC mux applies it when PC_MUX_SEL=2.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- INTR  in  1  level interrupt request, held until acknowledged
- BR_OP  in  4  flow class: 0 NONE, 1 BRN, 2 BREQ, 3 BRNE, 4 BRCS, 5 BRCC, 6 CALL, 7 RET, 8 RETID, 9 RETIE, 10 SEI, 11 CLI; 12-15 treated as NONE
- Z  in  1  zero flag
- C  in  1  carry flag
- RST_OUT  out  1  reset to PC, SP and flag registers
- IR_LD  out  1  latch instruction memory output into IR
- PC_INC  out  1  PC increment
- PC_LD  out  1  PC load
- PC_MUX_SEL  out  2  PC source: 0 IR immediate, 1 scratch RAM data (return address), 2 INT_VEC
- SP_INCR  out  1  SP increment
- SP_DECR  out  1  SP decrement
- SCR_WE  out  1  scratch RAM write (PC pushed)
- SCR_ADDR_SEL  out  1  scratch address: 0 = SP, 1 = SP-1
- FLG_SHAD_SAVE  out  1  copy Z/C into shadow
- FLG_SHAD_RESTORE  out  1  restore Z/C from shadow
- INT_ACK  out  1  interrupt accepted
- IE  out  1  interrupt-enable flag (registered)
- STATE  out  2  0 INIT, 1 FETCH, 2 EXEC, 3 INTERRUPT

## Operation
- States: INIT, FETCH, EXEC, INTERRUPT. State and IE are registered; all other outputs are combinational from the state, plus BR_OP/Z/C in EXEC. Any output not listed for a state is 0.
- INIT: RST_OUT=1. IE is cleared. Next state is FETCH.
- FETCH: IR_LD=1, PC_INC=1. Next state is EXEC.
- EXEC: acts on BR_OP:
  - BRN: PC_LD=1, PC_MUX_SEL=0.
  - BREQ/BRNE/BRCS/BRCC: same as BRN, only if Z=1 / Z=0 / C=1 / C=0 respectively. Otherwise no PC action; the PC already points to the next instruction.
  - CALL: PC_LD=1, PC_MUX_SEL=0, SCR_WE=1, SCR_ADDR_SEL=1, SP_DECR=1.
  - RET: PC_LD=1, PC_MUX_SEL=1, SCR_ADDR_SEL=0, SP_INCR=1.
  - RETID / RETIE: same as RET, plus FLG_SHAD_RESTORE=1. IE is written to 0 / 1.
  - SEI / CLI: IE is written to 1 / 0.
  - NONE / 12-15: no outputs.
- Leaving EXEC: the next state is INTERRUPT if INTR=1 and IE_next=1, otherwise FETCH. IE_next is the IE value after this EXEC's update. Consequences:
  - SEI or RETIE with INTR pending enters INTERRUPT immediately.
  - CLI or RETID blocks the interrupt.
- INTERRUPT: PC_LD=1, PC_MUX_SEL=2, SCR_WE=1, SCR_ADDR_SEL=1, SP_DECR=1, FLG_SHAD_SAVE=1, INT_ACK=1. IE is cleared. Next state is FETCH.
- Pushed return address: the PC value present during INTERRUPT. This is the branch/call target if EXEC loaded the PC, otherwise the incremented PC.
- INTR is only sampled in EXEC. A request asserted in FETCH or INTERRUPT waits for the next EXEC.

## Timing
- RST is sampled on the posedge CLK. When asserted, the next state is INIT and IE=0, regardless of the current state. This includes mid-EXEC and mid-INTERRUPT.
- Outputs while in INIT after reset: RST_OUT=1, STATE=0, everything else 0.
- One instruction = FETCH + EXEC = 2 cycles. Interrupt entry adds 1 cycle.
- All strobes are single-cycle. PC, SP and scratch RAM act on the posedge that ends the strobing state.
- Push: write at SP-1 and decrement SP on the same edge. Pop: read at SP (async scratch read) and increment SP on the same edge.
- RST held high keeps the FSM in INIT with RST_OUT=1 every cycle. FETCH follows the first cycle after RST falls.

## Test plan
- Reset: hold RST 3 cycles → STATE=0, RST_OUT=1, IE=0. Release → STATE sequence 1,2,1,2 with IR_LD/PC_INC=1 in each FETCH.
- Conditional branch: EXEC with BR_OP=2. Z=1 → PC_LD=1, PC_MUX_SEL=0. Z=0 → PC_LD=0. Repeat BR_OP=5 with C=0 → taken; C=1 → not taken.
- Call/return: EXEC BR_OP=6 → PC_LD=1, SCR_WE=1, SCR_ADDR_SEL=1, SP_DECR=1. A later EXEC with BR_OP=7 → PC_LD=1, PC_MUX_SEL=1, SP_INCR=1, SCR_WE=0.
- Interrupt: EXEC with BR_OP=10 and INTR=1 → next STATE=3 with PC_MUX_SEL=2, INT_ACK=1, FLG_SHAD_SAVE=1, SP_DECR=1; IE=0 afterward. Same EXEC with BR_OP=11 → next STATE=1, no INT_ACK.
- Masking/return: IE=0, INTR held high for 10 cycles → no INTERRUPT. Then EXEC BR_OP=9 → FLG_SHAD_RESTORE=1, SP_INCR=1, next STATE=3 since INTR is still high.
- Reset mid-interrupt: assert RST during STATE=3 → next cycle STATE=0, IE=0, INT_ACK=0, RST_OUT=1.
